// File: rtl/rf_wb_buffer_pkg.sv
// Shared register-file widths and the write-back entry type used by the
// write-back buffer and its bypass scan.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef RF_REG_W
`define RF_REG_W 5
`endif
`ifndef RF_REG_NUM
`define RF_REG_NUM 32
`endif

package rf_wb_buffer_pkg;

    localparam int RF_DATA_W  = `DATA_W;
    localparam int RF_REG_W   = `RF_REG_W;
    localparam int RF_REG_NUM = `RF_REG_NUM;
    localparam int WB_DEPTH   = 4;

    typedef struct packed {
        logic [RF_REG_W-1:0]  dst;
        logic [RF_DATA_W-1:0] data;
    } wbEntry_t;

    // Register 0 is hardwired to zero, so results aimed at it are dropped.
    function automatic logic isZeroReg(input logic [RF_REG_W-1:0] reg3);
        return reg3 == '0;
    endfunction

endpackage

// File: rtl/rf_wb_byp_match.sv
// Youngest-match scan over the occupied write-back entries, oldest to
// youngest starting at the head, so the last hit found is the youngest.
module rf_wb_byp_match #(
    parameter int DEPTH  = 4,
    parameter int REG_W  = 5,
    parameter int DATA_W = 32,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic [REG_W-1:0]  addr,
    input  logic [REG_W-1:0]  entryDst  [DEPTH],
    input  logic [DATA_W-1:0] entryData [DEPTH],
    input  logic [PTR_W-1:0]  headPtr,
    input  logic [CNT_W-1:0]  count,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = headPtr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (entryDst[idx] == addr) && (addr != '0)) begin
                hit  = 1'b1;
                data = entryData[idx];
            end
        end
    end

endmodule

// File: rtl/rf_wb_buffer.sv
// Write-back FIFO in front of the register file's shared read/write slot:
// queues ALU and load results, drains one write per idle slot, bypasses pending data.
module rf_wb_buffer
    import rf_wb_buffer_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int REG_W  = RF_REG_W,
    parameter int DEPTH  = WB_DEPTH
) (
    input  logic                         iClk,
    input  logic                         iReset,
    input  logic                         iAluValid,
    input  logic [REG_W-1:0]             iAluDst,
    input  logic [DATA_W-1:0]            iAluData,
    output logic                         oAluReady,
    input  logic                         iLdValid,
    input  logic [REG_W-1:0]             iLdDst,
    input  logic [DATA_W-1:0]            iLdData,
    output logic                         oLdReady,
    input  logic                         iRdBusy,
    output logic                         oRegWr,
    output logic [REG_W-1:0]             oWrReg3,
    output logic [DATA_W-1:0]            oWrData,
    input  logic [REG_W-1:0]             iByp1Addr,
    input  logic [REG_W-1:0]             iByp2Addr,
    output logic                         oByp1Hit,
    output logic                         oByp2Hit,
    output logic [DATA_W-1:0]            oByp1Data,
    output logic [DATA_W-1:0]            oByp2Data,
    output logic [$clog2(DEPTH+1)-1:0]   oCount
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [REG_W-1:0]  dstMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;

    logic [CNT_W:0]    free;
    logic [CNT_W:0]    ldNeed;
    logic              regWr;
    logic              aluReady;
    logic              ldReady;
    logic              aluPush;
    logic              ldPush;
    logic [PTR_W-1:0]  ldSlot;

    // A pop in this cycle frees a slot for a same-cycle push, so a full
    // buffer with an idle register file still accepts one result.
    always_comb begin
        regWr    = (count != '0) && !iRdBusy && !iReset;
        free     = (CNT_W+1)'(DEPTH) - {1'b0, count} + (CNT_W+1)'(regWr);
        ldNeed   = iAluValid ? (CNT_W+1)'(2) : (CNT_W+1)'(1);
        aluReady = free >= (CNT_W+1)'(1);
        ldReady  = free >= ldNeed;
        aluPush  = iAluValid && aluReady && !iReset && !isZeroReg(iAluDst);
        ldPush   = iLdValid && ldReady && !iReset && !isZeroReg(iLdDst);
        ldSlot   = wrPtr + PTR_W'(aluPush);
    end

    // Entry storage carries no reset; only pointers and occupancy matter.
    always_ff @(posedge iClk) begin
        if (aluPush) begin
            dstMem[wrPtr]  <= iAluDst;
            dataMem[wrPtr] <= iAluData;
        end
        if (ldPush) begin
            dstMem[ldSlot]  <= iLdDst;
            dataMem[ldSlot] <= iLdData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            wrPtr <= wrPtr + PTR_W'(aluPush) + PTR_W'(ldPush);
            rdPtr <= rdPtr + PTR_W'(regWr);
            count <= count + CNT_W'(aluPush) + CNT_W'(ldPush) - CNT_W'(regWr);
        end
    end

    rf_wb_byp_match #(
        .DEPTH  (DEPTH),
        .REG_W  (REG_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_byp1 (
        .addr      (iByp1Addr),
        .entryDst  (dstMem),
        .entryData (dataMem),
        .headPtr   (rdPtr),
        .count     (count),
        .hit       (oByp1Hit),
        .data      (oByp1Data)
    );

    rf_wb_byp_match #(
        .DEPTH  (DEPTH),
        .REG_W  (REG_W),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W),
        .CNT_W  (CNT_W)
    ) u_byp2 (
        .addr      (iByp2Addr),
        .entryDst  (dstMem),
        .entryData (dataMem),
        .headPtr   (rdPtr),
        .count     (count),
        .hit       (oByp2Hit),
        .data      (oByp2Data)
    );

    assign oAluReady = aluReady;
    assign oLdReady  = ldReady;
    assign oRegWr    = regWr;
    assign oWrReg3   = dstMem[rdPtr];
    assign oWrData   = dataMem[rdPtr];
    assign oCount    = count;

endmodule

// File: tb/tb_rf_wb_buffer.sv
// Bench for rf_wb_buffer: directed vector table, then randomized traffic
// checked against a queue-based reference model.
module tb_rf_wb_buffer;

    localparam int DEPTH = 4;

    logic        iClk;
    logic        iReset;
    logic        iAluValid;
    logic [4:0]  iAluDst;
    logic [31:0] iAluData;
    logic        oAluReady;
    logic        iLdValid;
    logic [4:0]  iLdDst;
    logic [31:0] iLdData;
    logic        oLdReady;
    logic        iRdBusy;
    logic        oRegWr;
    logic [4:0]  oWrReg3;
    logic [31:0] oWrData;
    logic [4:0]  iByp1Addr;
    logic [4:0]  iByp2Addr;
    logic        oByp1Hit;
    logic        oByp2Hit;
    logic [31:0] oByp1Data;
    logic [31:0] oByp2Data;
    logic [2:0]  oCount;

    rf_wb_buffer #(.DATA_W(32), .REG_W(5), .DEPTH(DEPTH)) dut (
        .iClk      (iClk),
        .iReset    (iReset),
        .iAluValid (iAluValid),
        .iAluDst   (iAluDst),
        .iAluData  (iAluData),
        .oAluReady (oAluReady),
        .iLdValid  (iLdValid),
        .iLdDst    (iLdDst),
        .iLdData   (iLdData),
        .oLdReady  (oLdReady),
        .iRdBusy   (iRdBusy),
        .oRegWr    (oRegWr),
        .oWrReg3   (oWrReg3),
        .oWrData   (oWrData),
        .iByp1Addr (iByp1Addr),
        .iByp2Addr (iByp2Addr),
        .oByp1Hit  (oByp1Hit),
        .oByp2Hit  (oByp2Hit),
        .oByp1Data (oByp1Data),
        .oByp2Data (oByp2Data),
        .oCount    (oCount)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
    } ent_t;
    ent_t q[$];

    typedef struct {
        logic        rst;
        logic        busy;
        logic        aV;
        logic [4:0]  aD;
        logic [31:0] aDat;
        logic        lV;
        logic [4:0]  lD;
        logic [31:0] lDat;
        logic [4:0]  b1;
        logic        chk;
        logic        eWr;
        logic [4:0]  eReg;
        logic [31:0] eDat;
        logic        eAR;
        logic        eLR;
        logic [2:0]  eCnt;
        logic        eHit;
        logic [31:0] eHD;
    } vec_t;

    vec_t tbl[26];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Youngest pending entry for an address, searched from the tail backwards.
    task automatic lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].dst == a) begin
                    hit = 1'b1;
                    d   = q[i].data;
                    break;
                end
            end
        end
    endtask

    // Drive one cycle, compare against the model before the edge, advance the model.
    task automatic step(input logic rst, input logic busy,
                        input logic aV, input logic [4:0] aD, input logic [31:0] aDat,
                        input logic lV, input logic [4:0] lD, input logic [31:0] lDat,
                        input logic [4:0] b1, input logic [4:0] b2, input logic doChk);
        int   n;
        int   freeSlots;
        logic eWr, eAR, eLR, h1, h2;
        logic [31:0] d1, d2;
        @(negedge iClk);
        iReset = rst; iRdBusy = busy;
        iAluValid = aV; iAluDst = aD; iAluData = aDat;
        iLdValid = lV; iLdDst = lD; iLdData = lDat;
        iByp1Addr = b1; iByp2Addr = b2;
        #1;
        n = q.size();
        eWr = (n > 0) && !busy && !rst;
        freeSlots = DEPTH - n + (eWr ? 1 : 0);
        eAR = freeSlots >= 1;
        eLR = freeSlots >= (aV ? 2 : 1);
        lookup(b1, h1, d1);
        lookup(b2, h2, d2);
        if (doChk) begin
            chk("m_count", 32'(oCount), 32'(n));
            chk("m_regwr", 32'(oRegWr), 32'(eWr));
            chk("m_alurdy", 32'(oAluReady), 32'(eAR));
            chk("m_ldrdy", 32'(oLdReady), 32'(eLR));
            chk("m_hit1", 32'(oByp1Hit), 32'(h1));
            chk("m_hit2", 32'(oByp2Hit), 32'(h2));
            if (eWr) begin
                chk("m_wrreg", 32'(oWrReg3), 32'(q[0].dst));
                chk("m_wrdata", oWrData, q[0].data);
            end
            if (h1) chk("m_bypdata1", oByp1Data, d1);
            if (h2) chk("m_bypdata2", oByp2Data, d2);
        end
        if (rst) begin
            q.delete();
        end else begin
            if (eWr) q.delete(0);
            if (aV && eAR && aD != 0) q.push_back('{aD, aDat});
            if (lV && eLR && lD != 0) q.push_back('{lD, lDat});
        end
    endtask

    initial begin
        int busyPct;
        iReset = 1'b1; iRdBusy = 1'b0;
        iAluValid = 1'b0; iAluDst = '0; iAluData = '0;
        iLdValid = 1'b0; iLdDst = '0; iLdData = '0;
        iByp1Addr = '0; iByp2Addr = '0;

        //          rst bsy aV aD aDat      lV lD lDat      b1  chk eWr eReg eDat     eAR eLR eCnt eHit eHD
        tbl[0]  = '{1, 0, 0, 0, 0,         0, 0, 0,        0,  0, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 5, 'h1234,    0, 0, 0,        5,  1, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[2]  = '{0, 0, 0, 0, 0,         0, 0, 0,        5,  1, 1, 5, 'h1234,    1, 1, 1, 1, 'h1234};
        tbl[3]  = '{0, 0, 0, 0, 0,         0, 0, 0,        5,  1, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 1, 'h11,      1, 2, 'h22,     1,  1, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 3, 'h33,      1, 4, 'h44,     2,  1, 0, 0, 0,         1, 1, 2, 1, 'h22};
        tbl[6]  = '{0, 1, 1, 6, 'h66,      1, 8, 'h88,     4,  1, 0, 0, 0,         0, 0, 4, 1, 'h44};
        tbl[7]  = '{0, 0, 0, 0, 0,         0, 0, 0,        1,  1, 1, 1, 'h11,      1, 1, 4, 1, 'h11};
        tbl[8]  = '{0, 0, 0, 0, 0,         0, 0, 0,        1,  1, 1, 2, 'h22,      1, 1, 3, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 0,         0, 0, 0,        3,  1, 1, 3, 'h33,      1, 1, 2, 1, 'h33};
        tbl[10] = '{0, 0, 0, 0, 0,         0, 0, 0,        4,  1, 1, 4, 'h44,      1, 1, 1, 1, 'h44};
        tbl[11] = '{0, 0, 0, 0, 0,         0, 0, 0,        4,  1, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[12] = '{0, 1, 1, 7, 'hA,       1, 7, 'hB,      7,  1, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[13] = '{0, 1, 0, 0, 0,         0, 0, 0,        7,  1, 0, 0, 0,         1, 1, 2, 1, 'hB};
        tbl[14] = '{0, 0, 0, 0, 0,         0, 0, 0,        7,  1, 1, 7, 'hA,       1, 1, 2, 1, 'hB};
        tbl[15] = '{0, 0, 0, 0, 0,         0, 0, 0,        7,  1, 1, 7, 'hB,       1, 1, 1, 1, 'hB};
        tbl[16] = '{0, 0, 0, 0, 0,         0, 0, 0,        7,  1, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[17] = '{0, 0, 1, 0, 'hFFFF,    0, 0, 0,        0,  1, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[18] = '{0, 0, 0, 0, 0,         0, 0, 0,        0,  1, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[19] = '{0, 1, 1, 1, 'h101,     1, 2, 'h202,    0,  1, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[20] = '{0, 1, 1, 3, 'h303,     1, 4, 'h404,    0,  1, 0, 0, 0,         1, 1, 2, 0, 0};
        tbl[21] = '{0, 0, 1, 5, 'h505,     1, 6, 'h606,    5,  1, 1, 1, 'h101,     1, 0, 4, 0, 0};
        tbl[22] = '{0, 1, 0, 0, 0,         0, 0, 0,        5,  1, 0, 0, 0,         0, 0, 4, 1, 'h505};
        tbl[23] = '{0, 0, 0, 0, 0,         0, 0, 0,        2,  1, 1, 2, 'h202,     1, 1, 4, 1, 'h202};
        tbl[24] = '{1, 0, 1, 9, 'h999,     1, 10, 'hAAA,   0,  0, 0, 0, 0,         1, 1, 0, 0, 0};
        tbl[25] = '{0, 0, 0, 0, 0,         0, 0, 0,        3,  1, 0, 0, 0,         1, 1, 0, 0, 0};

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].rst, tbl[i].busy, tbl[i].aV, tbl[i].aD, tbl[i].aDat,
                 tbl[i].lV, tbl[i].lD, tbl[i].lDat, tbl[i].b1, tbl[i].b1 + 5'd1,
                 tbl[i].chk && i > 0);
            if (tbl[i].chk) begin
                chk($sformatf("t%0d_count", i), 32'(oCount), 32'(tbl[i].eCnt));
                chk($sformatf("t%0d_regwr", i), 32'(oRegWr), 32'(tbl[i].eWr));
                chk($sformatf("t%0d_alurdy", i), 32'(oAluReady), 32'(tbl[i].eAR));
                chk($sformatf("t%0d_ldrdy", i), 32'(oLdReady), 32'(tbl[i].eLR));
                chk($sformatf("t%0d_hit1", i), 32'(oByp1Hit), 32'(tbl[i].eHit));
                if (tbl[i].eWr) begin
                    chk($sformatf("t%0d_wrreg", i), 32'(oWrReg3), 32'(tbl[i].eReg));
                    chk($sformatf("t%0d_wrdata", i), oWrData, tbl[i].eDat);
                end
                if (tbl[i].eHit) chk($sformatf("t%0d_bypdata", i), oByp1Data, tbl[i].eHD);
            end
        end

        busyPct = 50;
        for (int c = 0; c < 3000; c++) begin
            logic rst;
            if (c % 400 == 0) busyPct = (c / 400) % 3 == 0 ? 85 : ((c / 400) % 3 == 1 ? 15 : 50);
            rst = ($urandom_range(0, 249) == 0);
            step(rst, $urandom_range(0, 99) < busyPct,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), !rst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
